// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared types and constants for the digit-serial adder controller
`timescale 1ns/1ps
package serial_add_pkg;

    // Controller states; binary encoded.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits consumed per clock by the shared slice.
    localparam int DIGIT_W = 2;

    // Worst-case combinational delay through the slice; clk period must be >= 150 ns.
    localparam int SLICE_MAX_DELAY_NS = 112;

endpackage

// File: rtl/tma.sv
// rtl/tma.sv - 2-bit adder slice shared by the digit-serial controller
//
// Ports:
//   A[1:0], B[1:0]  addend digits
//   ci              carry in
//   S0, S1          sum bits (S0 = LSB)
//   CO              carry out
`timescale 1ns/1ps
module tma (
    input  logic [1:0] A,
    input  logic [1:0] B,
    input  logic       ci,
    output logic       S0,
    output logic       S1,
    output logic       CO
);

    logic [2:0] total;

    assign total        = {1'b0, A} + {1'b0, B} + {2'b00, ci};
    assign {CO, S1, S0} = total;

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - sequences an N-bit add/subtract through a 2-bit slice, LSB digit first
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-low reset
//   start   begin an operation (sampled only in IDLE)
//   op_sub  0 = a + b + cin, 1 = a - b (sampled with start)
//   a, b    operands (sampled with start)
//   cin     carry in for add; ignored for subtract
//   busy    high in RUN and DONE
//   done    one-cycle result-valid pulse
//   sum     result, held from done until the next accepted start
//   cout    final carry; for subtract 1 means no borrow (a >= b)
`timescale 1ns/1ps
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = (N / 2 > 1) ? $clog2(N / 2) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         op_sub,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam logic [CW-1:0] LAST_CNT = CW'(N / 2 - 1);

    state_t         state_q, state_d;
    logic [N-1:0]   areg_q, areg_d;
    logic [N-1:0]   breg_q, breg_d;
    logic [N-1:0]   sum_q, sum_d;
    logic           cout_q, cout_d;
    logic           carry_q, carry_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           s0, s1, s_co;
    logic [N-1:0]   digit_ext;

    // The controller is the only driver of the slice inputs.
    tma u_slice (
        .A  (areg_q[1:0]),
        .B  (breg_q[1:0]),
        .ci (carry_q),
        .S0 (s0),
        .S1 (s1),
        .CO (s_co)
    );

    // New digit enters at the top of the sum register as it shifts right.
    assign digit_ext = N'({s1, s0}) << (N - DIGIT_W);

    always_comb begin
        state_d = state_q;
        areg_d  = areg_q;
        breg_d  = breg_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    areg_d  = a;
                    // Subtract as a + ~b + 1.
                    breg_d  = op_sub ? ~b : b;
                    carry_d = op_sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d   = (sum_q >> DIGIT_W) | digit_ext;
                areg_d  = areg_q >> DIGIT_W;
                breg_d  = breg_q >> DIGIT_W;
                carry_d = s_co;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    cout_d  = s_co;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            areg_q  <= '0;
            breg_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            areg_q  <= areg_d;
            breg_q  <= breg_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - scoreboard bench for serial_add_ctrl
`timescale 1ns/1ps
module tb_serial_add_ctrl;

    localparam int N      = 8;
    localparam int PERIOD = N / 2 + 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         op_sub = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy, done;
    logic [N-1:0] sum;
    logic         cout;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int last_done = -1;
    bit b2b = 1'b0;

    logic [N:0] exp_q[$];

    serial_add_ctrl #(.N(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op_sub (op_sub),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .busy   (busy),
        .done   (done),
        .sum    (sum),
        .cout   (cout)
    );

    always #80 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #(160 * 20000);
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: {cout, sum} from plain modular arithmetic.
    function automatic logic [N:0] model(input logic [N-1:0] ta, input logic [N-1:0] tb,
                                         input logic ts, input logic tc);
        logic [N:0] r;
        if (!ts) begin
            r = {1'b0, ta} + {1'b0, tb} + {{N{1'b0}}, tc};
        end else begin
            r[N-1:0] = ta - tb;
            r[N]     = (ta >= tb);
        end
        return r;
    endfunction

    // Monitor: compares every done pulse against the scoreboard.
    initial begin : monitor
        logic       done_prev = 1'b0;
        logic       busy_prev = 1'b0;
        logic [N-1:0] sum_prev = '0;
        logic       cout_prev = 1'b0;
        logic [N:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (done) begin
                chk("done_implies_busy", {31'd0, busy}, 32'd1);
                chk("done_width", {31'd0, done_prev}, 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("result_sum", {24'd0, sum}, {24'd0, e[N-1:0]});
                    chk("result_cout", {31'd0, cout}, {31'd0, e[N]});
                end
                if (b2b && last_done >= 0)
                    chk("b2b_spacing", cyc - last_done, PERIOD);
                last_done = cyc;
            end
            if (!busy && !busy_prev && rst) begin
                chk("idle_sum_hold", {24'd0, sum}, {24'd0, sum_prev});
                chk("idle_cout_hold", {31'd0, cout}, {31'd0, cout_prev});
            end
            done_prev = done;
            busy_prev = busy;
            sum_prev  = sum;
            cout_prev = cout;
        end
    end

    task automatic wait_idle();
        int k = 0;
        @(negedge clk);
        while (busy !== 1'b0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (busy !== 1'b0) chk("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    // Returns at the negedge following the accepting edge.
    task automatic issue(input logic [N-1:0] ta, input logic [N-1:0] tb,
                         input logic ts, input logic tc, input bit push);
        wait_idle();
        a = ta; b = tb; op_sub = ts; cin = tc; start = 1'b1;
        if (push) exp_q.push_back(model(ta, tb, ts, tc));
        @(negedge clk);
        start = 1'b0;
        a = N'($urandom); b = N'($urandom); op_sub = 1'($urandom); cin = 1'($urandom);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_sum"},  {24'd0, sum},  32'd0);
        chk({tag, "_cout"}, {31'd0, cout}, 32'd0);
    endtask

    initial begin : driver
        logic [N-1:0] ra, rb;
        logic rs, rc;
        int gap;

        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b1;

        // Basic add plus latency / busy window.
        issue(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("lat_busy", {31'd0, busy}, 32'd1);
            chk("lat_done", {31'd0, done}, (i == 4) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        chk("lat_busy_end", {31'd0, busy}, 32'd0);

        issue(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
        issue(8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        issue(8'h10, 8'h01, 1'b1, 1'b1, 1'b1);
        issue(8'h01, 8'h02, 1'b1, 1'b0, 1'b1);

        // Start pulse while busy must be ignored.
        issue(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        a = 8'h11; b = 8'h11; op_sub = 1'b0; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        issue(8'h33, 8'h44, 1'b0, 1'b1, 1'b1);

        // Reset mid-operation abandons the op with no done.
        issue(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check_reset_state("midreset");
        issue(8'h01, 8'h01, 1'b0, 1'b0, 1'b1);

        // Back-to-back: start held high, accepted every PERIOD cycles.
        wait_idle();
        b2b = 1'b1;
        last_done = -1;
        for (int k = 0; k < 15; k++) begin
            a = N'($urandom); b = N'($urandom); op_sub = 1'($urandom); cin = 1'($urandom);
            start = 1'b1;
            if (k % PERIOD == 0) exp_q.push_back(model(a, b, op_sub, cin));
            @(negedge clk);
        end
        start = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);
        b2b = 1'b0;

        // Randomised operations with gaps and stray starts while busy.
        for (int n = 0; n < 40; n++) begin
            ra = N'($urandom); rb = N'($urandom);
            rs = 1'($urandom); rc = 1'($urandom);
            if (n % 8 == 0) rb = ra;
            issue(ra, rb, rs, rc, 1'b1);
            if ($urandom_range(0, 9) < 3) begin
                gap = $urandom_range(0, 3);
                repeat (gap) @(negedge clk);
                a = N'($urandom); b = N'($urandom); start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
        end

        wait_idle();
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
